// File: rtl/div_share_pkg.sv
// ---------------------------------------------------------------------------
// div_share_pkg
//   Shared types and helpers for div_share_arbiter.
//   - div_share_state_t : controller states
//   - SAT_POS / SAT_NEG : divide-by-zero saturation quotients
//   - abs_mag()         : two's-complement value -> unsigned magnitude
//   - apply_sign()      : unsigned magnitude -> two's-complement value
//   The helpers work at DIV_WIDTH bits. Their negation wraps, so the
//   magnitude of -2^(W-1) comes out as 2^(W-1) in unsigned form.
// ---------------------------------------------------------------------------
package div_share_pkg;

   localparam int DIV_WIDTH = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } div_share_state_t;

   localparam logic [DIV_WIDTH-1:0] SAT_POS = {1'b0, {(DIV_WIDTH-1){1'b1}}};
   localparam logic [DIV_WIDTH-1:0] SAT_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};

   function automatic logic [DIV_WIDTH-1:0] abs_mag(input logic [DIV_WIDTH-1:0] x);
      return x[DIV_WIDTH-1] ? -x : x;
   endfunction

   function automatic logic [DIV_WIDTH-1:0] apply_sign(input logic [DIV_WIDTH-1:0] mag,
                                                       input logic                 neg);
      return neg ? -mag : mag;
   endfunction

endpackage

// File: rtl/div_share_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin grant. The scan starts at rr_ptr+1 and wraps
//   modulo NUM_REQ. The first valid requester found receives a one-hot grant.
//   Ports:
//     req_valid  in  NUM_REQ  request valids
//     rr_ptr     in  PTR_W    index of the last requester served
//     grant      out NUM_REQ  one-hot grant (zero when nothing is valid)
//     grant_idx  out PTR_W    binary index of the grant (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx
);

   logic             found;
   logic [PTR_W-1:0] scan_idx;

   // NOTE: every signal written in an always_comb gets a default first;
   // a path that skips an assignment would otherwise infer a latch.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      scan_idx  = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         scan_idx = PTR_W'((int'(rr_ptr) + off) % NUM_REQ);
         if (!found && req_valid[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            grant_idx       = scan_idx;
            found           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_share_arbiter.sv
// ---------------------------------------------------------------------------
// div_share_arbiter
//   Shares one blocking unsigned divider between NUM_REQ signed-division
//   requesters. Arbitration is round-robin. Operands go to the divider as
//   magnitudes, and result signs are restored on return (truncation toward
//   zero). Divide-by-zero is answered locally with a saturated quotient. A
//   divider that never answers yields a timeout response. Only one division
//   is in flight at a time.
//   Ports:
//     clk_in, rst_in                  clock, async active-low reset
//     req_valid_in / req_ready_out    per-requester handshake (ready one-hot)
//     req_dividend_in/req_divisor_in  signed operands, requester i at [i*WIDTH +: WIDTH]
//     resp_valid_out                  one-hot, one-cycle response strobe
//     resp_quotient_out/remainder_out signed results (valid in strobe cycle)
//     resp_div0_out, resp_timeout_out response flags
//     busy_out                        high whenever not IDLE
//     div_valid_out                   one-cycle divider start pulse
//     div_dividend_out/div_divisor_out operand magnitudes to the divider
//     div_valid_in, div_quotient_in, div_remainder_in  divider result
//   WIDTH must equal div_share_pkg::DIV_WIDTH, because the sign helpers are
//   sized by the package.
// ---------------------------------------------------------------------------
module div_share_arbiter
   import div_share_pkg::*;
#(
   parameter int WIDTH       = DIV_WIDTH,
   parameter int NUM_REQ     = 3,
   parameter int DIV_TIMEOUT = 100
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic [NUM_REQ-1:0]         req_valid_in,
   input  logic [NUM_REQ*WIDTH-1:0]   req_dividend_in,
   input  logic [NUM_REQ*WIDTH-1:0]   req_divisor_in,
   output logic [NUM_REQ-1:0]         req_ready_out,
   output logic [NUM_REQ-1:0]         resp_valid_out,
   output logic [WIDTH-1:0]           resp_quotient_out,
   output logic [WIDTH-1:0]           resp_remainder_out,
   output logic                       resp_div0_out,
   output logic                       resp_timeout_out,
   output logic                       busy_out,
   output logic                       div_valid_out,
   output logic [WIDTH-1:0]           div_dividend_out,
   output logic [WIDTH-1:0]           div_divisor_out,
   input  logic                       div_valid_in,
   input  logic [WIDTH-1:0]           div_quotient_in,
   input  logic [WIDTH-1:0]           div_remainder_in
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

   div_share_state_t state, state_nxt;

   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   gnt_idx;
   logic [PTR_W-1:0]   arb_idx;
   logic [NUM_REQ-1:0] arb_grant;
   logic               handshake;
   logic [WIDTH-1:0]   sel_dividend;
   logic [WIDTH-1:0]   sel_divisor;
   logic               sel_div0;

   logic               dividend_neg;
   logic               quot_neg;
   logic [WIDTH-1:0]   dividend_mag;
   logic [WIDTH-1:0]   divisor_mag;
   logic [CNT_W-1:0]   wait_cnt;
   logic               timeout_hit;
   logic [WIDTH-1:0]   quot_q;
   logic [WIDTH-1:0]   rem_q;
   logic               div0_q;
   logic               timeout_q;

   // ---------------- arbitration ----------------
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req_valid (req_valid_in),
      .rr_ptr    (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx)
   );

   // The grant is also masked by reset, so every output reads 0 while
   // rst_in is low, including this combinational one.
   assign req_ready_out = (state == ST_IDLE && rst_in) ? arb_grant : '0;
   assign handshake     = |(req_valid_in & req_ready_out);

   always_comb begin
      sel_dividend = '0;
      sel_divisor  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == PTR_W'(i)) begin
            sel_dividend = req_dividend_in[i*WIDTH +: WIDTH];
            sel_divisor  = req_divisor_in[i*WIDTH +: WIDTH];
         end
      end
   end

   assign sel_div0    = (sel_divisor == '0);
   assign timeout_hit = (wait_cnt == CNT_W'(DIV_TIMEOUT - 1));

   // ---------------- controller ----------------
   // NOTE: sequential state is updated with non-blocking assignments only,
   // so every flop samples the pre-edge values regardless of block order.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (handshake) state_nxt = sel_div0 ? ST_RESPOND : ST_ISSUE;
         ST_ISSUE:   state_nxt = ST_WAIT;
         ST_WAIT:    if (div_valid_in || timeout_hit) state_nxt = ST_RESPOND;
         ST_RESPOND: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   // NOTE: the datapath registers get an async reset as well, because
   // every output, including the operand and result buses, must read 0
   // during reset. Without that requirement they could be left unreset.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rr_ptr       <= PTR_W'(NUM_REQ - 1);
         gnt_idx      <= '0;
         dividend_neg <= 1'b0;
         quot_neg     <= 1'b0;
         dividend_mag <= '0;
         divisor_mag  <= '0;
         wait_cnt     <= '0;
         quot_q       <= '0;
         rem_q        <= '0;
         div0_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (handshake) begin
                  gnt_idx      <= arb_idx;
                  rr_ptr       <= arb_idx;
                  dividend_neg <= sel_dividend[WIDTH-1];
                  quot_neg     <= sel_dividend[WIDTH-1] ^ sel_divisor[WIDTH-1];
                  dividend_mag <= abs_mag(sel_dividend);
                  divisor_mag  <= abs_mag(sel_divisor);
                  timeout_q    <= 1'b0;
                  div0_q       <= sel_div0;
                  if (sel_div0) begin
                     // Saturate toward the dividend's sign; remainder is the dividend.
                     quot_q <= sel_dividend[WIDTH-1] ? SAT_NEG : SAT_POS;
                     rem_q  <= sel_dividend;
                  end
               end
            end
            ST_ISSUE: wait_cnt <= '0;
            ST_WAIT: begin
               // A divider result wins over a timeout that expires in the same cycle.
               if (div_valid_in) begin
                  quot_q <= apply_sign(div_quotient_in, quot_neg);
                  rem_q  <= apply_sign(div_remainder_in, dividend_neg);
               end else if (timeout_hit) begin
                  quot_q    <= '0;
                  rem_q     <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      resp_valid_out = '0;
      if (state == ST_RESPOND) resp_valid_out[gnt_idx] = 1'b1;
   end

   assign busy_out           = (state != ST_IDLE);
   assign div_valid_out      = (state == ST_ISSUE);
   assign div_dividend_out   = dividend_mag;
   assign div_divisor_out    = divisor_mag;
   assign resp_quotient_out  = quot_q;
   assign resp_remainder_out = rem_q;
   assign resp_div0_out      = div0_q;
   assign resp_timeout_out   = timeout_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_share_arbiter
//   Self-checking bench for div_share_arbiter. It contains a behavioural
//   divider with programmable latency and hang mode. A signed reference
//   model uses plain integer division.
// ---------------------------------------------------------------------------
module tb_div_share_arbiter;

   localparam int WIDTH       = 64;
   localparam int NUM_REQ     = 3;
   localparam int DIV_TIMEOUT = 100;
   localparam logic [63:0] MIN_V = 64'h8000_0000_0000_0000;
   localparam logic [63:0] MAX_V = 64'h7fff_ffff_ffff_ffff;

   logic                     clk_in = 1'b0;
   logic                     rst_in;
   logic [NUM_REQ-1:0]       req_valid_in;
   logic [NUM_REQ*WIDTH-1:0] req_dividend_in;
   logic [NUM_REQ*WIDTH-1:0] req_divisor_in;
   logic [NUM_REQ-1:0]       req_ready_out;
   logic [NUM_REQ-1:0]       resp_valid_out;
   logic [WIDTH-1:0]         resp_quotient_out;
   logic [WIDTH-1:0]         resp_remainder_out;
   logic                     resp_div0_out;
   logic                     resp_timeout_out;
   logic                     busy_out;
   logic                     div_valid_out;
   logic [WIDTH-1:0]         div_dividend_out;
   logic [WIDTH-1:0]         div_divisor_out;
   logic                     div_valid_in;
   logic [WIDTH-1:0]         div_quotient_in;
   logic [WIDTH-1:0]         div_remainder_in;

   int checks   = 0;
   int failures = 0;

   always #5 clk_in = ~clk_in;

   div_share_arbiter #(
      .WIDTH       (WIDTH),
      .NUM_REQ     (NUM_REQ),
      .DIV_TIMEOUT (DIV_TIMEOUT)
   ) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .req_valid_in       (req_valid_in),
      .req_dividend_in    (req_dividend_in),
      .req_divisor_in     (req_divisor_in),
      .req_ready_out      (req_ready_out),
      .resp_valid_out     (resp_valid_out),
      .resp_quotient_out  (resp_quotient_out),
      .resp_remainder_out (resp_remainder_out),
      .resp_div0_out      (resp_div0_out),
      .resp_timeout_out   (resp_timeout_out),
      .busy_out           (busy_out),
      .div_valid_out      (div_valid_out),
      .div_dividend_out   (div_dividend_out),
      .div_divisor_out    (div_divisor_out),
      .div_valid_in       (div_valid_in),
      .div_quotient_in    (div_quotient_in),
      .div_remainder_in   (div_remainder_in)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      if ($countones(v) != 1) return -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference model: signed division truncating toward zero, plus the
   // divide-by-zero and MIN/-1 wrap rules.
   function automatic void ref_div(input logic signed [63:0] dd, input logic signed [63:0] dv,
                                   output logic [63:0] q, output logic [63:0] r, output bit d0);
      d0 = 1'b0;
      if (dv == 0) begin
         d0 = 1'b1;
         q  = (dd < 0) ? MIN_V : MAX_V;
         r  = dd;
      end else if (dd == $signed(MIN_V) && dv == -1) begin
         q = MIN_V;
         r = 64'd0;
      end else begin
         q = dd / dv;
         r = dd % dv;
      end
   endfunction

   function automatic logic [63:0] mag(input logic signed [63:0] x);
      return (x < 0) ? 64'(-x) : 64'(x);
   endfunction

   // ---------------- behavioural divider ----------------
   int          div_lat    = 4;
   bit          div_hang   = 1'b0;
   int          div_starts = 0;
   logic [63:0] div_a_seen = '0;
   logic [63:0] div_b_seen = '0;

   initial begin
      div_valid_in     = 1'b0;
      div_quotient_in  = '0;
      div_remainder_in = '0;
      forever begin
         @(posedge clk_in); #1;
         if (div_valid_out === 1'b1) begin
            div_starts++;
            div_a_seen = div_dividend_out;
            div_b_seen = div_divisor_out;
            if (!div_hang) begin
               repeat (div_lat) @(posedge clk_in);
               #1;
               div_valid_in     = 1'b1;
               div_quotient_in  = div_a_seen / div_b_seen;
               div_remainder_in = div_a_seen % div_b_seen;
               @(posedge clk_in); #1;
               div_valid_in     = 1'b0;
            end
         end
      end
   end

   // ---------------- transaction driver ----------------
   // k counts cycles after the handshake edge E0: k=1 is cycle E0+1.
   task automatic do_txn(input int idx, input logic [63:0] dd, input logic [63:0] dv, input int lat,
                         output bit got, output int ridx, output int k,
                         output logic [63:0] q, output logic [63:0] r, output logic d0, output logic to);
      int budget;
      div_lat = lat;
      got = 1'b0; ridx = -1; k = 0; q = '0; r = '0; d0 = 1'b0; to = 1'b0;
      budget = 0;
      while (busy_out !== 1'b0 && budget < 300) begin
         @(posedge clk_in); #1; budget++;
      end
      req_dividend_in[idx*WIDTH +: WIDTH] = dd;
      req_divisor_in[idx*WIDTH +: WIDTH]  = dv;
      req_valid_in[idx] = 1'b1;
      #1;
      budget = 0;
      while (req_ready_out[idx] !== 1'b1 && budget < 20) begin
         @(posedge clk_in); #2; budget++;
      end
      if (req_ready_out[idx] !== 1'b1) begin
         check("grant_wait", 64'(req_ready_out[idx]), 64'd1);
         req_valid_in[idx] = 1'b0;
         return;
      end
      @(posedge clk_in); #1;
      req_valid_in[idx] = 1'b0;
      k = 1;
      while (resp_valid_out == '0 && k < 400) begin
         @(posedge clk_in); #1; k++;
      end
      if (resp_valid_out != '0) begin
         got  = 1'b1;
         ridx = onehot_idx(resp_valid_out);
         q    = resp_quotient_out;
         r    = resp_remainder_out;
         d0   = resp_div0_out;
         to   = resp_timeout_out;
      end
   endtask

   task automatic run_and_check(input string name, input int idx, input logic [63:0] dd,
                                input logic [63:0] dv, input int lat,
                                input logic [63:0] exp_q, input logic [63:0] exp_r,
                                input bit exp_d0, input bit exp_to, input int exp_k);
      bit got; int ridx, k; logic [63:0] q, r; logic d0, to; int starts0;
      starts0 = div_starts;
      do_txn(idx, dd, dv, lat, got, ridx, k, q, r, d0, to);
      check({name, "_resp"},    64'(got), 64'd1);
      check({name, "_idx"},     64'(ridx), 64'(idx));
      check({name, "_latency"}, 64'(k), 64'(exp_k));
      check({name, "_q"},       q, exp_q);
      check({name, "_r"},       r, exp_r);
      check({name, "_div0"},    64'(d0), 64'(exp_d0));
      check({name, "_timeout"}, 64'(to), 64'(exp_to));
      check({name, "_starts"},  64'(div_starts - starts0), exp_d0 ? 64'd0 : 64'd1);
   endtask

   task automatic reset_dut();
      rst_in = 1'b0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   typedef struct {
      int          idx;
      logic [63:0] dd, dv;
      int          lat;
      logic [63:0] exp_q, exp_r;
      bit          exp_d0;
      logic [63:0] exp_ma, exp_mb;
   } vec_t;

   vec_t vecs[10];

   initial begin
      bit          got;
      int          ridx, k, g, bad_resp;
      int          order[6];
      int          exp_order[6];
      logic [63:0] q, r, eq, er, dd, dv;
      logic        d0, to;
      bit          ed0;
      int          lat, idx, sel;

      vecs[0] = '{0, 64'd100,   64'd7,   64, 64'd14,   64'd2,   1'b0, 64'd100, 64'd7};
      vecs[1] = '{1, -64'sd100, 64'd7,   3,  -64'sd14, -64'sd2, 1'b0, 64'd100, 64'd7};
      vecs[2] = '{2, 64'd100,   -64'sd7, 3,  -64'sd14, 64'd2,   1'b0, 64'd100, 64'd7};
      vecs[3] = '{0, -64'sd100, -64'sd7, 5,  64'd14,   -64'sd2, 1'b0, 64'd100, 64'd7};
      vecs[4] = '{1, -64'sd5,   64'd0,   2,  MIN_V,    -64'sd5, 1'b1, 64'd0,   64'd0};
      vecs[5] = '{2, 64'd7,     64'd0,   2,  MAX_V,    64'd7,   1'b1, 64'd0,   64'd0};
      vecs[6] = '{0, MIN_V,     64'd1,   2,  MIN_V,    64'd0,   1'b0, MIN_V,   64'd1};
      vecs[7] = '{1, MIN_V,     -64'sd1, 2,  MIN_V,    64'd0,   1'b0, MIN_V,   64'd1};
      vecs[8] = '{2, 64'd0,     64'd5,   1,  64'd0,    64'd0,   1'b0, 64'd0,   64'd5};
      vecs[9] = '{0, MAX_V,     -64'sd1, 1,  64'h8000_0000_0000_0001, 64'd0, 1'b0, MAX_V, 64'd1};

      rst_in          = 1'b0;
      req_valid_in    = '0;
      req_dividend_in = '0;
      req_divisor_in  = '0;

      // ---------------- reset state ----------------
      #12;
      check("rst_busy",      64'(busy_out), 64'd0);
      check("rst_ready",     64'(req_ready_out), 64'd0);
      check("rst_resp",      64'(resp_valid_out), 64'd0);
      check("rst_div_valid", 64'(div_valid_out), 64'd0);
      check("rst_quot",      resp_quotient_out, 64'd0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in); #1;

      // ---------------- directed vectors ----------------
      for (int i = 0; i < 10; i++) begin
         run_and_check($sformatf("vec%0d", i), vecs[i].idx, vecs[i].dd, vecs[i].dv, vecs[i].lat,
                       vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_d0, 1'b0,
                       vecs[i].exp_d0 ? 1 : vecs[i].lat + 2);
         if (!vecs[i].exp_d0) begin
            check($sformatf("vec%0d_div_a", i), div_a_seen, vecs[i].exp_ma);
            check($sformatf("vec%0d_div_b", i), div_b_seen, vecs[i].exp_mb);
         end
      end

      // ---------------- randomized against reference model ----------------
      for (int n = 0; n < 40; n++) begin
         idx = $urandom_range(0, NUM_REQ - 1);
         lat = $urandom_range(1, 6);
         sel = $urandom_range(0, 5);
         if (sel == 0)      dd = {$urandom, $urandom};
         else if (sel == 1) dd = MIN_V;
         else               dd = 64'(longint'($urandom_range(0, 2000)) - 64'sd1000);
         sel = $urandom_range(0, 9);
         if (sel < 2)       dv = 64'd0;
         else if (sel == 2) dv = -64'sd1;
         else if (sel == 3) dv = {$urandom, $urandom};
         else               dv = 64'(longint'($urandom_range(0, 60)) - 64'sd30);
         ref_div(dd, dv, eq, er, ed0);
         run_and_check($sformatf("rnd%0d", n), idx, dd, dv, lat, eq, er, ed0, 1'b0,
                       ed0 ? 1 : lat + 2);
         if (!ed0) begin
            check($sformatf("rnd%0d_div_a", n), div_a_seen, mag(dd));
            check($sformatf("rnd%0d_div_b", n), div_b_seen, mag(dv));
         end
      end

      // ---------------- divider timeout ----------------
      div_hang = 1'b1;
      run_and_check("timeout", 2, 64'd50, 64'd3, 4, 64'd0, 64'd0, 1'b0, 1'b1, DIV_TIMEOUT + 2);
      div_hang = 1'b0;
      run_and_check("after_timeout", 1, -64'sd9, 64'd2, 2, -64'sd4, -64'sd1, 1'b0, 1'b0, 4);

      // ---------------- round robin ----------------
      reset_dut();
      div_lat = 2;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_dividend_in[i*WIDTH +: WIDTH] = 64'(10 * (i + 1));
         req_divisor_in[i*WIDTH +: WIDTH]  = 64'd3;
      end
      req_valid_in = '1;
      exp_order = '{0, 1, 2, 0, 2, 0};
      for (int n = 0; n < 6; n++) begin
         if (n == 4) req_valid_in[1] = 1'b0;
         k = 0;
         #1;
         while (req_ready_out == '0 && k < 20) begin
            @(posedge clk_in); #1; k++;
         end
         g = onehot_idx(req_ready_out);
         order[n] = g;
         @(posedge clk_in); #1;
         check($sformatf("rr%0d_ready_busy", n), 64'(req_ready_out), 64'd0);
         k = 1;
         while (resp_valid_out == '0 && k < 50) begin
            @(posedge clk_in); #1; k++;
         end
         check($sformatf("rr%0d_grant", n), 64'(order[n]), 64'(exp_order[n]));
         check($sformatf("rr%0d_resp_idx", n), 64'(onehot_idx(resp_valid_out)), 64'(g));
         if (g >= 0) begin
            ref_div(64'(10 * (g + 1)), 64'd3, eq, er, ed0);
            check($sformatf("rr%0d_q", n), resp_quotient_out, eq);
         end
      end
      req_valid_in = '0;
      @(posedge clk_in); #1;

      // ---------------- async reset during WAIT ----------------
      div_lat = 20;
      do_txn_start: begin
         req_dividend_in[1*WIDTH +: WIDTH] = 64'd1000;
         req_divisor_in[1*WIDTH +: WIDTH]  = 64'd3;
         req_valid_in[1] = 1'b1;
         #1;
         k = 0;
         while (req_ready_out[1] !== 1'b1 && k < 20) begin
            @(posedge clk_in); #2; k++;
         end
         @(posedge clk_in); #1;
         req_valid_in[1] = 1'b0;
      end
      repeat (5) @(posedge clk_in);
      #1;
      check("wait_busy", 64'(busy_out), 64'd1);
      #2;
      req_valid_in = 3'b010;
      rst_in = 1'b0;
      #1;
      check("arst_busy",      64'(busy_out), 64'd0);
      check("arst_ready",     64'(req_ready_out), 64'd0);
      check("arst_resp",      64'(resp_valid_out), 64'd0);
      check("arst_div_valid", 64'(div_valid_out), 64'd0);
      check("arst_div_a",     div_dividend_out, 64'd0);
      check("arst_div_b",     div_divisor_out, 64'd0);
      check("arst_quot",      resp_quotient_out, 64'd0);
      check("arst_rem",       resp_remainder_out, 64'd0);
      check("arst_flags",     64'({resp_div0_out, resp_timeout_out}), 64'd0);
      req_valid_in = '0;
      @(negedge clk_in);
      rst_in = 1'b1;
      bad_resp = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk_in); #1;
         if (resp_valid_out != '0) bad_resp++;
      end
      check("late_div_no_resp", 64'(bad_resp), 64'd0);
      div_lat = 2;
      req_dividend_in[0*WIDTH +: WIDTH] = 64'd21;
      req_divisor_in[0*WIDTH +: WIDTH]  = 64'd4;
      req_valid_in = 3'b011;
      #1;
      check("post_rst_grant", 64'(req_ready_out), 64'd1);
      @(posedge clk_in); #1;
      req_valid_in = '0;
      k = 1;
      while (resp_valid_out == '0 && k < 50) begin
         @(posedge clk_in); #1; k++;
      end
      check("post_rst_resp", 64'(resp_valid_out), 64'd1);
      check("post_rst_q",    resp_quotient_out, 64'd5);
      check("post_rst_r",    resp_remainder_out, 64'd1);
      repeat (3) @(posedge clk_in);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
Shares one blocking unsigned divider (divider2, WIDTH-bit) between several signed-division requesters in the formant pipeline, such as the phi, LPC-coefficient and bandwidth stages. It runs round-robin arbitration and converts operands from signed to magnitude before issue. It restores result signs, short-circuits divide-by-zero and guards against a hung divider with a timeout. Only one division is in flight at a time.

Parameters:
WIDTH, 64, operand/result width (two's complement on requester side, unsigned on divider side)
NUM_REQ, 3, number of requesters
DIV_TIMEOUT, 100, maximum WAIT cycles before the error response

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous, active-low reset
req_valid_in  in  NUM_REQ  per-requester request valid
req_dividend_in  in  NUM_REQ*WIDTH  signed dividends, requester i at [i*WIDTH +: WIDTH]
req_divisor_in  in  NUM_REQ*WIDTH  signed divisors, same packing
req_ready_out  out  NUM_REQ  one-hot grant; transfer when valid&ready
resp_valid_out  out  NUM_REQ  one-hot, one-cycle response strobe to the owning requester
resp_quotient_out  out  WIDTH  signed quotient (shared bus)
resp_remainder_out  out  WIDTH  signed remainder (shared bus)
resp_div0_out  out  1  response was divide-by-zero
resp_timeout_out  out  1  response was a divider timeout
busy_out  out  1  high whenever state != IDLE
div_valid_out  out  1  one-cycle start pulse to the divider
div_dividend_out  out  WIDTH  |dividend|
div_divisor_out  out  WIDTH  |divisor|
div_valid_in  in  1  divider result valid
div_quotient_in  in  WIDTH  unsigned quotient
div_remainder_in  in  WIDTH  unsigned remainder

Behaviour:
- Reset (rst_in low, async): state IDLE; all outputs 0; rr_ptr = NUM_REQ-1, so requester 0 wins first. Reset mid-operation abandons the division with no response. A late div_valid_in after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE, grant selection: req_ready_out is combinational. It is one-hot on the first valid requester scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ. It is zero when no request is valid or state != IDLE.
- IDLE, on handshake (edge E0):
  - Latch grant index g, operand signs and magnitudes; set rr_ptr <= g.
  - If divisor == 0, go to RESPOND; otherwise go to ISSUE.
- ISSUE: div_valid_out = 1 for exactly this cycle, with magnitudes on div_dividend_out/div_divisor_out (held stable until RESPOND). Next state is WAIT. Timeout counter clears.
- WAIT: on div_valid_in, latch sign-corrected results and go to RESPOND. Otherwise increment the counter. When the counter reaches DIV_TIMEOUT-1 without div_valid_in, latch quotient 0, remainder 0, resp_timeout_out=1, and go to RESPOND. div_valid_in arriving in any state other than WAIT is ignored.
- RESPOND: resp_valid_out[g] = 1 for one cycle. Quotient, remainder and flag buses are valid only in this cycle (held afterwards, don't-care). Next state is IDLE. A new grant is possible in the cycle after RESPOND (no combinational IDLE bypass).
- Latency: with divider latency L (div_valid_in high L cycles after div_valid_out), resp_valid_out is high in cycle E0+L+2. For divide-by-zero it is high in cycle E0+1.
- Sign rules (truncate toward zero):
  - quotient negative iff sign(dividend) ^ sign(divisor);
  - remainder takes the sign of the dividend;
  - magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which is representable unsigned;
  - negation is WIDTH-bit two's complement, wrapping; the (-2^(W-1))/(-1) result wraps to -2^(W-1).
- Divide-by-zero: quotient = 2^(W-1)-1 if dividend >= 0, else -2^(W-1). Remainder = dividend. resp_div0_out=1. The divider is not started.
- Requests that are valid but not granted keep waiting. Requesters must hold valid and operands until ready; the block does not check this.

Decomposition:
- Package div_share_pkg holds:
  - state enum div_share_state_t;
  - functions abs_mag(x) and apply_sign(mag, neg);
  - saturation constants SAT_POS/SAT_NEG per WIDTH.
- Sub-module rr_arbiter (NUM_REQ): combinational one-hot grant from req_valid and rr_ptr.
- divider2 is instantiated outside this block.

Test Plan:
- Single request: req0 dividend 100, divisor 7; model divider L=64 → div operands 100/7; resp_valid_out[0] at E0+66; q=14, r=2, flags 0.
- Signs: -100/7 → q=-14, r=-2; 100/-7 → q=-14, r=2; -100/-7 → q=14, r=-2.
- Round robin: all three valid continuously from reset → grants 0,1,2,0; a requester dropping valid is skipped.
- Divide-by-zero: req1 dividend -5, divisor 0 → no div_valid_out; resp_valid_out[1] at E0+1; q=SAT_NEG, r=-5, resp_div0_out=1.
- Timeout and edge values: divider never asserts valid → response at WAIT count 100, q=0, resp_timeout_out=1. Then -2^63/1 → |dividend| = 2^63, q=-2^63.
- Async reset asserted during WAIT → all outputs 0 immediately; a late div_valid_in produces no response; the next grant goes to requester 0.
